// File: rtl/and_64_reg.sv
// and_64_reg: registered bitwise AND for the andq ALU path.
// A per-bit gate array forms A & B combinationally; the result and its
// condition flags are captured together on the rising edge so the flags
// always describe exactly the value presented on OUTPUT.
module and_64_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] OUTPUT,
    output logic             out_valid,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    // Zero detection is split into byte-wide OR groups so the reduction
    // stays a shallow, regular tree instead of one wide OR.
    localparam int GROUP  = 8;
    localparam int NGROUP = (WIDTH + GROUP - 1) / GROUP;

    logic [WIDTH-1:0]  and_bus;
    logic [NGROUP-1:0] group_any;
    logic              zf_next;
    logic              sf_next;

    logic [WIDTH-1:0]  result_reg;
    logic              valid_reg;
    logic              zf_reg;
    logic              sf_reg;
    logic              of_reg;

    // One two-input AND gate per bit; no bit depends on any other.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_and
            and u_and (and_bus[gi], A[gi], B[gi]);
        end
    endgenerate

    // First level of the zero detector: does each byte hold any set bit.
    generate
        for (genvar gi = 0; gi < NGROUP; gi++) begin : g_group
            localparam int LO = gi * GROUP;
            localparam int HI = ((gi + 1) * GROUP > WIDTH) ? WIDTH - 1 : (gi + 1) * GROUP - 1;
            assign group_any[gi] = |and_bus[HI:LO];
        end
    endgenerate

    // Flags computed from the same combinational bus that feeds the result
    // register, so zf and sf can never disagree with OUTPUT.
    always_comb begin
        zf_next = ~|group_any;
        sf_next = and_bus[WIDTH-1];
    end

    // Result/flag register: reset clears everything and wins over in_valid;
    // a valid operand pair captures, otherwise the last result is held and
    // only out_valid drops.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_reg <= '0;
            valid_reg  <= 1'b0;
            zf_reg     <= 1'b0;
            sf_reg     <= 1'b0;
            of_reg     <= 1'b0;
        end else begin
            valid_reg <= in_valid;
            if (in_valid) begin
                result_reg <= and_bus;
                zf_reg     <= zf_next;
                sf_reg     <= sf_next;
                // A logical AND can never overflow.
                of_reg     <= 1'b0;
            end
        end
    end

    assign OUTPUT    = result_reg;
    assign out_valid = valid_reg;
    assign zf        = zf_reg;
    assign sf        = sf_reg;
    assign of        = of_reg;

endmodule

// File: tb/tb_and_64_reg.sv
// Bench for and_64_reg: a directed vector table, a mid-stream reset
// sequence, then randomized traffic against a behavioural model.
module tb_and_64_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] out;
    logic        out_valid;
    logic        zf;
    logic        sf;
    logic        of;

    int compared   = 0;
    int mismatched = 0;

    and_64_reg #(.WIDTH(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .OUTPUT    (out),
        .out_valid (out_valid),
        .zf        (zf),
        .sf        (sf),
        .of        (of)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        in_valid;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_out;
        logic        exp_valid;
        logic        exp_zf;
        logic        exp_sf;
    } vec_t;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MAXP = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINN = 64'h8000_0000_0000_0000;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%016h expected 0x%016h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, let the edge pass, sample 1 ns later.
    task automatic cycle(input logic r, input logic v, input logic [63:0] aa, input logic [63:0] bb);
        rst_n    = r;
        in_valid = v;
        a        = aa;
        b        = bb;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [63:0] e_out, input logic e_v,
                             input logic e_zf, input logic e_sf);
        check({tag, ".out"},   out,       e_out);
        check({tag, ".valid"}, {63'd0, out_valid}, {63'd0, e_v});
        check({tag, ".zf"},    {63'd0, zf},        {63'd0, e_zf});
        check({tag, ".sf"},    {63'd0, sf},        {63'd0, e_sf});
        check({tag, ".of"},    {63'd0, of},        64'd0);
    endtask

    // Behavioural model state
    logic [63:0] m_out;
    logic        m_valid;
    logic        m_zf;
    logic        m_sf;

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;

        //            rst   v     A     B     OUT    vld   zf    sf
        vecs[0]  = '{1'b0, 1'b1, ONES, ONES, 64'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, ONES, ONES, 64'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 64'd0, 64'd0, 64'd0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, MAXP, MAXP, MAXP, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, MINN, MINN, MINN, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, MAXP, MINN, 64'd0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, MINN, MAXP, 64'd0, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, ONES, MINN, MINN, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 64'h5, 64'hE, 64'h4, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, ONES, ONES, 64'h4, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b0, ONES, ONES, 64'd0, 1'b0, 1'b0, 1'b0};

        for (int i = 0; i < 11; i++) begin
            cycle(vecs[i].rst_n, vecs[i].in_valid, vecs[i].a, vecs[i].b);
            check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid,
                      vecs[i].exp_zf, vecs[i].exp_sf);
            $display("vec%0d: rst_n=%0b v=%0b A=%016h B=%016h -> OUT=%016h ov=%0b zf=%0b sf=%0b",
                     i, vecs[i].rst_n, vecs[i].in_valid, vecs[i].a, vecs[i].b, out, out_valid, zf, sf);
        end

        // Back-to-back results, then reset mid-stream overriding in_valid.
        cycle(1'b1, 1'b1, 64'hF0F0_0000_0000_00FF, 64'hFF00_0000_0000_000F);
        check_all("b2b0", 64'hF000_0000_0000_000F, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 64'h0000_1234_0000_0000, 64'h0000_FFFF_0000_0000);
        check_all("b2b1", 64'h0000_1234_0000_0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, ONES, ONES);
        check_all("midrst", 64'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, ONES, ONES);
        check_all("postrst_idle", 64'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, MINN, ONES);
        check_all("postrst_cap", MINN, 1'b1, 1'b0, 1'b1);
        $display("seq: mid-stream reset sequence done");

        // Randomized traffic against the model.
        m_out = out; m_valid = out_valid; m_zf = zf; m_sf = sf;
        m_out = MINN; m_valid = 1'b1; m_zf = 1'b0; m_sf = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic        r, v;
            logic [63:0] ra, rb;
            r  = ($urandom_range(0, 49) != 0);
            v  = ($urandom_range(0, 3) != 0);
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = ~ra;
                1: rb = ra;
                2: rb = ~ra | MINN;
                default: ;
            endcase
            if (!r) begin
                m_out = 64'd0; m_valid = 1'b0; m_zf = 1'b0; m_sf = 1'b0;
            end else begin
                m_valid = v;
                if (v) begin
                    m_out = ra & rb;
                    m_zf  = (m_out == 64'd0);
                    m_sf  = (m_out >= MINN);
                end
            end
            cycle(r, v, ra, rb);
            check_all($sformatf("rnd%0d", i), m_out, m_valid, m_zf, m_sf);
        end
        $display("rnd: 1000 random cycles done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
